// File: rtl/freq_div_multi.sv
// Multi-channel 50% duty clock divider with per-channel runtime-loadable half-period.
// Optional FREQ_DIV_SYNC_EN macro adds a 'sync' input that restarts every channel at once.
module freq_div_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 32,
  parameter int DIV_RST = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              load,
  input  logic [3:0]        load_ch,
  input  logic [CNT_W-1:0]  load_val,
`ifdef FREQ_DIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic w_syncRestart;

`ifdef FREQ_DIV_SYNC_EN
  assign w_syncRestart = sync;
`else
  assign w_syncRestart = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             w_loadHit;
    logic             w_restart;
    logic             w_wrap;
    logic [CNT_W-1:0] w_lastCnt;

    // An out-of-range load_ch never matches any channel index, so it is ignored.
    assign w_loadHit = load && (int'(load_ch) == g);
    assign w_restart = w_loadHit || w_syncRestart;
    assign w_lastCnt = (r_div == '0) ? '0 : r_div - CNT_W'(1);
    assign w_wrap    = en[g] && (r_cnt == w_lastCnt);

    // Restart has priority over a coinciding wrap, so a load on the wrap cycle never ticks.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_div  <= CNT_W'(DIV_RST);
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (w_loadHit) begin
          r_div <= load_val;
        end
        if (w_restart) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          if (en[g]) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          r_tick <= 1'b0;
        end
      end
    end

    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed self-checking bench for freq_div_multi (NUM_CH=3, defaults).
// Expected waveforms come from a closed-form per-channel phase reference: restart edge and half-period.
module tb_freq_div_multi;

  logic        clock;
  logic        reset;
  logic [2:0]  en;
  logic        load;
  logic [3:0]  load_ch;
  logic [31:0] load_val;
  logic [2:0]  clk_out;
  logic [2:0]  tick;
`ifdef FREQ_DIV_SYNC_EN
  logic        sync;
`endif

  int tests;
  int failures;
  int k;
  int refEdge [3];
  int hEff [3];
  logic [2:0] lastExpClk;

  freq_div_multi #(.NUM_CH(3), .CNT_W(32), .DIV_RST(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_ch  (load_ch),
    .load_val (load_val),
`ifdef FREQ_DIV_SYNC_EN
    .sync     (sync),
`endif
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic expClk(input int m, input int h);
    return ((m / h) % 2) == 1;
  endfunction

  function automatic logic expTick(input int m, input int h);
    return (m > 0) && ((m % (2 * h)) == h);
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] eClk, input logic [2:0] eTick);
    tests++;
    assert (clk_out === eClk) else begin
      failures++;
      $error("[TB] FAIL %s clk_out k=%0d observed=%b expected=%b", tag, k, clk_out, eClk);
    end
    tests++;
    assert (tick === eTick) else begin
      failures++;
      $error("[TB] FAIL %s tick k=%0d observed=%b expected=%b", tag, k, tick, eTick);
    end
  endtask

  // A disabled channel's phase reference slides forward one edge, which holds its output.
  task automatic runCycles(input int n, input string tag);
    logic [2:0] eClk;
    logic [2:0] eTick;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      k++;
      for (int i = 0; i < 3; i++) begin
        int m;
        if (!en[i]) refEdge[i]++;
        m = k - refEdge[i];
        eClk[i]  = expClk(m, hEff[i]);
        eTick[i] = en[i] ? expTick(m, hEff[i]) : 1'b0;
      end
      lastExpClk = eClk;
      checkOutput(tag, eClk, eTick);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ch, input logic [31:0] val, input string tag);
    load     = 1'b1;
    load_ch  = ch;
    load_val = val;
    if (ch < 4'd3) begin
      refEdge[ch] = k + 1;
      hEff[ch]    = (val == 0) ? 1 : int'(val);
    end
    runCycles(1, tag);
    load = 1'b0;
  endtask

  task automatic restartModel();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      refEdge[i] = 0;
      hEff[i]    = 2;
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset    = 1'b1;
    en       = 3'b000;
    load     = 1'b0;
    load_ch  = 4'd0;
    load_val = 32'd0;
    lastExpClk = 3'b000;
`ifdef FREQ_DIV_SYNC_EN
    sync     = 1'b0;
`endif
    restartModel();

    repeat (2) @(negedge clock);
    checkOutput("resetState", 3'b000, 3'b000);

    reset = 1'b0;
    en    = 3'b111;
    runCycles(6, "defaultDiv");

    applyStimulus(4'd1, 32'd5, "loadCh1");
    runCycles(18, "ch1Period10");

    applyStimulus(4'd2, 32'd0, "loadCh2H0");
    runCycles(6, "ch2H0");
    applyStimulus(4'd2, 32'd1, "loadCh2H1");
    runCycles(4, "ch2H1");
    applyStimulus(4'd7, 32'd9, "loadOutOfRange");
    runCycles(4, "afterBadLoad");

    applyStimulus(4'd0, 32'd4, "loadCh0H4");
    runCycles(5, "ch0H4");
    en = 3'b110;
    runCycles(3, "ch0Frozen");
    en = 3'b111;
    runCycles(12, "ch0Resumed");

    for (int w = 0; w < 10 && ((k + 1 - refEdge[1]) % 10) != 5; w++) begin
      runCycles(1, "preWrap");
    end
    applyStimulus(4'd1, 32'd3, "loadOnWrap");
    runCycles(8, "ch1H3");

    for (int w = 0; w < 8 && lastExpClk == 3'b000; w++) begin
      runCycles(1, "preReset");
    end
    @(posedge clock);
    #3;
    reset    = 1'b1;
    load     = 1'b1;
    load_ch  = 4'd0;
    load_val = 32'd9;
    #1;
    checkOutput("asyncReset", 3'b000, 3'b000);
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
    checkOutput("resetHeld", 3'b000, 3'b000);
    reset = 1'b0;
    restartModel();
    runCycles(8, "afterReset");

`ifdef FREQ_DIV_SYNC_EN
    applyStimulus(4'd1, 32'd4, "syncPrepCh1");
    applyStimulus(4'd2, 32'd6, "syncPrepCh2");
    runCycles(5, "preSync");
    sync = 1'b1;
    for (int i = 0; i < 3; i++) refEdge[i] = k + 1;
    applyStimulus(4'd0, 32'd3, "syncWithLoad");
    sync = 1'b0;
    runCycles(26, "syncAligned");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
